// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 6-digit 7-segment driver.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [31:0] MAX_VAL     = 32'd999_999;
  localparam logic [7:0]  SEG_MINUS   = 8'hBF;
  localparam logic [7:0]  SEG_BLANK   = 8'hFF;
  localparam logic [7:0]  SEG_DP_MASK = 8'h7F;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential binary-to-BCD converter: IDLE -> LOAD -> SHIFT x20 -> DONE,
// 23 cycles per pass. Inputs are only sampled in LOAD; done_o marks a valid result.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_DIGITS-1:0] point_i,
  input  logic                  sign_i,
  output logic [BCD_W-1:0]      bcd_o,
  output logic [NUM_DIGITS-1:0] point_o,
  output logic                  sign_o,
  output logic                  done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] LAST_SHIFT = 5'(BIN_W - 1);

  logic [1:0]            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] point_q, point_d;
  logic                  sign_q, sign_d;
  logic [BIN_W-1:0]      clamp_s;
  logic [BCD_W-1:0]      bcd_adj_s;

  assign clamp_s   = (data_i > MAX_VAL) ? MAX_VAL[BIN_W-1:0] : data_i[BIN_W-1:0];
  assign bcd_adj_s = bcd_add3(bcd_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    point_d = point_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bin_d   = clamp_s;
        bcd_d   = '0;
        cnt_d   = 5'd0;
        point_d = point_i;
        sign_d  = sign_i;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      bin_q   <= '0;
      bcd_q   <= '0;
      point_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      point_q <= point_d;
      sign_q  <= sign_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign point_o = point_q;
  assign sign_o  = sign_q;
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: rtl/seg_dynamic_drv.sv
// 6-digit common-anode 7-segment scanner with leading-zero blanking, sign and decimal points.
// Conversion results land atomically in a display buffer; outputs are registered from the scan index.
module seg_dynamic_drv
  import seg_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [31:0]           data,
  input  logic [NUM_DIGITS-1:0] point,
  input  logic                  en,
  input  logic                  sign,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic [7:0]            seg_led
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]            IDX_MAX = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{1'b1}};

  logic [BCD_W-1:0]      conv_bcd_s;
  logic [NUM_DIGITS-1:0] conv_point_s;
  logic                  conv_sign_s;
  logic                  conv_done_s;

  logic [BCD_W-1:0]      buf_bcd_q, buf_bcd_d;
  logic [NUM_DIGITS-1:0] buf_point_q, buf_point_d;
  logic                  buf_sign_q, buf_sign_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            led_q, led_d;

  logic [2:0]            msd_s, pmax_s, top_s;
  logic [3:0]            nib_s;
  logic [7:0]            digit_s;

  bin2bcd_seq u_bin2bcd (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .data_i  (data),
    .point_i (point),
    .sign_i  (sign),
    .bcd_o   (conv_bcd_s),
    .point_o (conv_point_s),
    .sign_o  (conv_sign_s),
    .done_o  (conv_done_s)
  );

  // Buffer is only touched on done, so a display never sees a half-converted value.
  always_comb begin
    if (conv_done_s) begin
      buf_bcd_d   = conv_bcd_s;
      buf_point_d = conv_point_s;
      buf_sign_d  = conv_sign_s;
    end else begin
      buf_bcd_d   = buf_bcd_q;
      buf_point_d = buf_point_q;
      buf_sign_d  = buf_sign_q;
    end
  end

  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // top = highest position that must show a digit (significant digit or lit dp).
  always_comb begin
    msd_s  = 3'd0;
    pmax_s = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (buf_bcd_q[4*k +: 4] != 4'd0) begin
        msd_s = 3'(k);
      end else begin
        msd_s = msd_s;
      end
      if (buf_point_q[k]) begin
        pmax_s = 3'(k);
      end else begin
        pmax_s = pmax_s;
      end
    end
    top_s = (pmax_s > msd_s) ? pmax_s : msd_s;
  end

  always_comb begin
    nib_s = buf_bcd_q[{idx_q, 2'b00} +: 4];
    if (idx_q <= top_s) begin
      if (buf_point_q[idx_q]) begin
        digit_s = seg_code(nib_s) & SEG_DP_MASK;
      end else begin
        digit_s = seg_code(nib_s);
      end
    end else if (buf_sign_q && (idx_q == top_s + 3'd1)) begin
      digit_s = SEG_MINUS;
    end else begin
      digit_s = SEG_BLANK;
    end
  end

  always_comb begin
    if (en) begin
      sel_d = ~(SEL_ONE << idx_q);
      led_d = digit_s;
    end else begin
      sel_d = SEL_OFF;
      led_d = SEG_BLANK;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      buf_bcd_q   <= '0;
      buf_point_q <= '0;
      buf_sign_q  <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sel_q       <= SEL_OFF;
      led_q       <= SEG_BLANK;
    end else begin
      buf_bcd_q   <= buf_bcd_d;
      buf_point_q <= buf_point_d;
      buf_sign_q  <= buf_sign_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      led_q       <= led_d;
    end
  end

  assign seg_sel = sel_q;
  assign seg_led = led_q;

endmodule

// File: tb/tb_seg_dynamic_drv.sv
// Directed bench for seg_dynamic_drv with an 8-cycle scan period.
module tb_seg_dynamic_drv;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;
  bit seen_bad = 1'b0;

  seg_dynamic_drv #(
    .CLK_FREQ  (8000),
    .SCAN_FREQ (1000)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .en      (en),
    .sign    (sign),
    .seg_sel (seg_sel),
    .seg_led (seg_led)
  );

  always #5 sys_clk = ~sys_clk;

  // While displaying 0 then 42, only these codes may ever appear.
  always @(negedge sys_clk) begin
    if (mon_on && !(seg_led === 8'hC0 || seg_led === 8'hA4 ||
                    seg_led === 8'h99 || seg_led === 8'hFF))
      seen_bad <= 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_sel(input string tag, input logic [5:0] target);
    int n = 0;
    while (seg_sel !== target && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, {2'b00, seg_sel}, {2'b00, target});
  endtask

  // exp holds digit0 in bits [7:0] up to digit5 in bits [47:40].
  task automatic scan_check(input string tag, input logic [47:0] exp);
    logic [5:0] sel;
    wait_sel({tag, " sync"}, 6'b111110);
    for (int d = 0; d < 6; d++) begin
      sel = ~(6'b000001 << d);
      check($sformatf("%s sel%0d", tag, d), {2'b00, seg_sel}, {2'b00, sel});
      check($sformatf("%s led%0d", tag, d), seg_led, exp[8*d +: 8]);
      repeat (8) @(negedge sys_clk);
    end
  endtask

  task automatic apply(input logic [31:0] d, input logic [5:0] p, input logic s);
    data  = d;
    point = p;
    sign  = s;
    repeat (50) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst = 1'b1;
    en      = 1'b1;
    data    = 32'd0;
    point   = 6'd0;
    sign    = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset sel", {2'b00, seg_sel}, 8'h3F);
    check("reset led", seg_led, 8'hFF);

    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("post-reset sel", {2'b00, seg_sel}, 8'h3E);
    check("post-reset led", seg_led, 8'hC0);

    apply(32'd123456, 6'b000000, 1'b0);
    scan_check("123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    apply(32'd5, 6'b000000, 1'b1);
    scan_check("-5", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h92});

    apply(32'd5, 6'b000010, 1'b0);
    scan_check("0.5", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h92});

    apply(32'd1_000_000, 6'b000000, 1'b1);
    scan_check("clamp", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

    apply(32'd1000, 6'b000100, 1'b1);
    scan_check("-10.00", {8'hFF, 8'hBF, 8'hF9, 8'h40, 8'hC0, 8'hC0});

    // Blank while disabled, then resume on the same digit.
    wait_sel("en sync", 6'b110111);
    en = 1'b0;
    @(negedge sys_clk);
    check("en0 sel", {2'b00, seg_sel}, 8'h3F);
    check("en0 led", seg_led, 8'hFF);
    en = 1'b1;
    @(negedge sys_clk);
    check("en1 sel", {2'b00, seg_sel}, 8'h37);
    check("en1 led", seg_led, 8'hF9);

    // Reset during SHIFT of 777777, then convert 42.
    data    = 32'd777777;
    point   = 6'd0;
    sign    = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    mon_on  = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_rst = 1'b1;
    data    = 32'd42;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (45) @(negedge sys_clk);
    scan_check("42", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});
    mon_on = 1'b0;
    @(negedge sys_clk);
    check("no partial value", {7'd0, seen_bad}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
